i2c_read_sequencer: RTL

I2C_READ_SEQUENCER -- requirements
Module: i2c_read_sequencer

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_quarter_tick.sv | 32 +++
 rtl/i2c_read_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding, bit-phase constants and divider helper
// for the I2C temperature read sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, SACK, RDMSB, MACK, RDLSB, MNACK, STOP, FINISH
    } state_t;

    // Quarters of one bit period: SCL low, low, high, high.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic int quarter_clocks(input int clk_hz, input int baud);
        return clk_hz / (4 * baud);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-cycle tick every quarter SCL period while enabled.
// Ports: clock, Reset (sync, active high), enable (count while high, clear
// otherwise), tick (registered one-cycle pulse).
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int ClockFrequency = 60000000,
    parameter int BaudRate       = 30000
) (
    input  logic clock,
    input  logic Reset,
    input  logic enable,
    output logic tick
);

    localparam int Quarter = quarter_clocks(ClockFrequency, BaudRate);
    localparam int Width   = Quarter > 1 ? $clog2(Quarter) : 1;
    localparam logic [Width-1:0] Last = Width'(Quarter - 1);

    logic [Width-1:0] count;

    always_ff @(posedge clock) begin
        if (Reset || !enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= count == Last;
            count <= count == Last ? '0 : count + Width'(1);
        end
    end

endmodule

// File: rtl/i2c_read_sequencer.sv
// i2c_read_sequencer: reads a 16-bit temperature word from a TMP101-style
// I2C slave (START, address+R, two data bytes with ACK/NACK, STOP).
// Ports: clock, Reset (sync, active high), Go (start request), SCL,
// SDA_pull_low (1 = drive SDA low), SDA_in (bus level), Busy, Done (one-cycle
// pulse), AckError (address not acknowledged), Temperature {MSB, LSB}.
module i2c_read_sequencer
    import i2c_pkg::*;
#(
    parameter int         ClockFrequency = 60000000,
    parameter int         BaudRate       = 30000,
    parameter logic [6:0] SlaveAddress   = 7'b1001000
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        Go,
    output logic        SCL,
    output logic        SDA_pull_low,
    input  logic        SDA_in,
    output logic        Busy,
    output logic        Done,
    output logic        AckError,
    output logic [15:0] Temperature
);

    localparam logic [7:0] AddrByte = {SlaveAddress, 1'b1};

    state_t     state;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] msb_byte;
    logic       tick;

    i2c_quarter_tick #(
        .ClockFrequency(ClockFrequency),
        .BaudRate      (BaudRate)
    ) u_tick (
        .clock (clock),
        .Reset (Reset),
        .enable(Busy),
        .tick  (tick)
    );

    always_ff @(posedge clock) begin
        Done <= 1'b0;
        if (Reset) begin
            state        <= IDLE;
            phase        <= Q0;
            bit_cnt      <= 3'd0;
            shreg        <= 8'h00;
            msb_byte     <= 8'h00;
            SCL          <= 1'b1;
            SDA_pull_low <= 1'b0;
            Busy         <= 1'b0;
            AckError     <= 1'b0;
            Temperature  <= 16'h0000;
        end else begin
            case (state)
                IDLE: if (Go) begin
                    state        <= START;
                    phase        <= Q0;
                    Busy         <= 1'b1;
                    AckError     <= 1'b0;
                    SDA_pull_low <= 1'b1;
                end
                // SDA already low with SCL high; hold two quarters, then drop
                // SCL and present the first address bit together.
                START: if (tick) begin
                    phase <= phase + 2'd1;
                    if (phase == Q1) begin
                        state        <= ADDR;
                        phase        <= Q0;
                        SCL          <= 1'b0;
                        shreg        <= AddrByte;
                        SDA_pull_low <= ~AddrByte[7];
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                // Bit-framed states share the quarter sequencing; per-state
                // work happens when the bit period closes (end of Q3).
                default: if (tick) begin
                    phase <= phase + 2'd1;
                    if (phase == Q1)
                        SCL <= 1'b1;
                    if (phase == Q2 && (state == RDMSB || state == RDLSB))
                        shreg <= {shreg[6:0], SDA_in};
                    if (phase == Q2 && state == SACK)
                        AckError <= SDA_in;
                    if (phase == Q3) begin
                        SCL <= state == STOP;
                        case (state)
                            ADDR: begin
                                bit_cnt      <= bit_cnt + 3'd1;
                                shreg        <= {shreg[6:0], 1'b0};
                                SDA_pull_low <= bit_cnt == 3'd7 ? 1'b0 : ~shreg[6];
                                if (bit_cnt == 3'd7)
                                    state <= SACK;
                            end
                            // AckError was sampled at Q2; a NACK goes straight
                            // to STOP, which begins with SDA low.
                            SACK: begin
                                state        <= AckError ? STOP : RDMSB;
                                SDA_pull_low <= AckError;
                            end
                            RDMSB: begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state        <= MACK;
                                    SDA_pull_low <= 1'b1;
                                    msb_byte     <= shreg;
                                end
                            end
                            MACK: begin
                                state        <= RDLSB;
                                SDA_pull_low <= 1'b0;
                            end
                            RDLSB: begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7)
                                    state <= MNACK;
                            end
                            MNACK: begin
                                state        <= STOP;
                                SDA_pull_low <= 1'b1;
                            end
                            // SCL is already high; releasing SDA now is the STOP.
                            STOP: begin
                                state        <= FINISH;
                                SDA_pull_low <= 1'b0;
                                Done         <= 1'b1;
                                if (!AckError)
                                    Temperature <= {msb_byte, shreg};
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
